operand_issue: RTL and testbench
================================

Name: operand_issue

Overview:
- Decode/operand-fetch stage that drives the execute-stage ALU.
- Accepts one 16-bit instruction per cycle and decodes it into the 12-bit one-hot alusignals vector.
- Reads the 8x16 architectural register file (r7 = compare flags) and presents op1/op2/immx/isimmediate to the ALU one cycle later.
- Holds a busy-bit scoreboard that stalls issue on RAW/WAW hazards until writeback retires the producing register.

Parameters:
- NREGS, 8, number of architectural registers (r7 is the flags register).
- DW, 16, data and instruction width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  instrin holds a valid instruction.
- in_ready  output  1  stage accepts instrin this cycle (in_valid & in_ready = issue).
- instrin  input  16  instruction.
- wb_en  input  1  writeback strobe from the writeback stage.
- wb_addr  input  3  writeback destination register.
- wb_data  input  16  writeback value.
- alusignals  output  12  one-hot op. Bit order: add, ld, st, sub, mul, cmp, mov, or, and, not, lsl, lsr (bit 0 = add).
- op1  output  16  rs1 value.
- op2  output  16  rs2 value (zero when isimmediate=1).
- immx  output  5  imm5 field.
- isimmediate  output  1  B operand is immx.
- st_data  output  16  rd value for st, else 0.
- instrout  output  16  issued instruction.
- out_valid  output  1  outputs hold an issued instruction.
- stall_count  output  16  saturating count of cycles with in_valid=1 and in_ready=0.

Behaviour:

Encoding:
- [15:12] opcode, [11] I, [10:8] rd, [7:5] rs1, [4:0] imm5 when I=1, [4:2] rs2 when I=0.
- Opcode n (0..11) sets alusignals bit n.
- Opcodes 12-15 are NOPs: alusignals=0, no sources, no destination. They still issue, with out_valid=1.

Sources:
- rs1 for every op except mov.
- rs2 when I=0 for add, ld, st, sub, mul, cmp, mov, or, and, lsl, lsr. not never reads rs2.
- rd is an additional source for st.

Destination:
- rd for add, ld, sub, mul, mov, or, and, not, lsl, lsr.
- r7 for cmp.
- None for st and NOPs.

Register file:
- Written on wb_en at the clock edge.
- A read of wb_addr in the same cycle that wb_en=1 returns wb_data (bypass).

Scoreboard:
- busy[7:0].
- On wb_en, busy[wb_addr] clears.
- On issue with a destination, busy[dest] sets. If both happen on the same register in one edge, set wins.

Stall rule:
- in_ready = 0 when any required source, or the destination, has busy=1 and is not cleared by wb_en/wb_addr in the same cycle.
- Otherwise in_ready = 1.
- in_ready is combinational from busy, instrin and wb_*.

Output latency:
- Exactly 1 cycle. On an issue edge all outputs load the decoded/read values and out_valid becomes 1.
- On a non-issue edge, out_valid becomes 0 and alusignals becomes 0. Other outputs hold their values.

Output values:
- op2 = 0 when I=1.
- immx = instrin[4:0] always.
- isimmediate = I bit, forced 0 for NOPs.
- No back-pressure from the ALU.

stall_count:
- Increments on each cycle with in_valid & ~in_ready.
- Saturates at 16'hFFFF.

Reset (synchronous, highest priority):
- All registers and busy bits are 0.
- All outputs are 0, stall_count = 0.
- A wb_en asserted in the same cycle as rst is ignored.
- Reset during a stall drops the pending instruction; upstream must re-present it.

Boundary cases:
- wb to r7 is legal and updates the flags.
- Back-to-back independent instructions issue every cycle.
- A self-dependent instruction (e.g. add r1,r1,r1 with r1 free) issues.

Test Plan:
- Reset, then wb r1=0x0005, r2=0x0003; issue add r3,r1,r2 (I=0) -> next cycle alusignals=0x001, op1=0x0005, op2=0x0003, isimmediate=0, out_valid=1, busy[3]=1.
- Issue sub r4,r3,imm 2 while busy[3]=1, no wb -> in_ready=0 and stall_count increments each cycle. Then wb r3=0x0008 in the same cycle -> issues; op1=0x0008 (bypass), immx=2, alusignals=0x008.
- cmp r1,r2 then immediately not r5,r7 -> not stalls until wb r7=0x0002; then op1=0x0002, alusignals=0x200.
- st r2,[r1+imm 4] with r1=0x0010, r2=0x00AA -> alusignals=0x004, op1=0x0010, immx=4, st_data=0x00AA; no busy bit set.
- Opcode 0xE, then in_valid=0 for one cycle -> first out_valid=1 with alusignals=0; next cycle out_valid=0, alusignals=0.
- Assert rst while stalled with busy[3]=1 and stall_count=5 -> next cycle busy=0, stall_count=0, all outputs 0; a wb_en in the reset cycle leaves the register at 0.

Source files
------------

// File: rtl/operand_issue_if.sv
// Handshake, writeback and ALU-facing signals of the operand issue stage.
// The slave modport is the stage itself; master is whatever drives it.
interface operand_issue_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] instrin;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [11:0]   alusignals;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [4:0]    immx;
  logic          isimmediate;
  logic [DW-1:0] st_data;
  logic [DW-1:0] instrout;
  logic          out_valid;
  logic [15:0]   stall_count;

  modport slave (
    input  in_valid, instrin, wb_en, wb_addr, wb_data,
    output in_ready, alusignals, op1, op2, immx, isimmediate,
           st_data, instrout, out_valid, stall_count
  );

  modport master (
    output in_valid, instrin, wb_en, wb_addr, wb_data,
    input  in_ready, alusignals, op1, op2, immx, isimmediate,
           st_data, instrout, out_valid, stall_count
  );
endinterface

// File: rtl/operand_issue.sv
// Decode/operand-fetch stage: decodes one instruction per cycle, reads the
// register file with writeback bypass and stalls on busy-bit hazards.
module operand_issue #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic           clk,
  input  logic           rst,
  operand_issue_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [3:0] OP_ST  = 4'd2;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [AW-1:0] FLAGS_REG = AW'(NREGS - 1);

  logic [DW-1:0]    regs [NREGS];
  logic [NREGS-1:0] busy;

  logic [3:0]       opcode;
  logic             i_bit;
  logic [AW-1:0]    rd, rs1, rs2, dest;
  logic             is_op, use_rs1, use_rs2, use_rd, has_dest;
  logic [NREGS-1:0] wb_mask, set_mask, pending;
  logic             ready, issue;
  logic [DW-1:0]    rs1_val, rs2_val, rd_val;
  logic [11:0]      alu_dec;

  logic [11:0]      alusignals_q;
  logic [DW-1:0]    op1_q, op2_q, st_data_q, instrout_q;
  logic [4:0]       immx_q;
  logic             isimm_q, out_valid_q;
  logic [15:0]      stall_q;

  assign opcode = bus.instrin[15:12];
  assign i_bit  = bus.instrin[11];
  assign rd     = bus.instrin[10:8];
  assign rs1    = bus.instrin[7:5];
  assign rs2    = bus.instrin[4:2];

  always_comb begin
    is_op    = opcode < 4'd12;
    use_rs1  = is_op && (opcode != OP_MOV);
    use_rs2  = is_op && !i_bit && (opcode != OP_NOT);
    use_rd   = (opcode == OP_ST);
    has_dest = is_op && (opcode != OP_ST);
    dest     = (opcode == OP_CMP) ? FLAGS_REG : rd;

    // A register retiring this very cycle no longer blocks issue.
    wb_mask = '0;
    if (bus.wb_en) wb_mask[bus.wb_addr] = 1'b1;
    pending = busy & ~wb_mask;

    ready = !((use_rs1  && pending[rs1]) ||
              (use_rs2  && pending[rs2]) ||
              (use_rd   && pending[rd])  ||
              (has_dest && pending[dest]));
    issue = bus.in_valid && ready;

    set_mask = '0;
    if (issue && has_dest) set_mask[dest] = 1'b1;

    rs1_val = (bus.wb_en && bus.wb_addr == rs1) ? bus.wb_data : regs[rs1];
    rs2_val = (bus.wb_en && bus.wb_addr == rs2) ? bus.wb_data : regs[rs2];
    rd_val  = (bus.wb_en && bus.wb_addr == rd)  ? bus.wb_data : regs[rd];

    alu_dec = '0;
    if (is_op) alu_dec[opcode] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy         <= '0;
      alusignals_q <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      immx_q       <= '0;
      isimm_q      <= 1'b0;
      st_data_q    <= '0;
      instrout_q   <= '0;
      out_valid_q  <= 1'b0;
      stall_q      <= '0;
    end else begin
      if (bus.wb_en) regs[bus.wb_addr] <= bus.wb_data;
      // Set after clear: a same-edge issue to the retiring register keeps it busy.
      busy <= (busy & ~wb_mask) | set_mask;

      if (bus.in_valid && !ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;

      if (issue) begin
        alusignals_q <= alu_dec;
        op1_q        <= rs1_val;
        op2_q        <= i_bit ? '0 : rs2_val;
        immx_q       <= bus.instrin[4:0];
        isimm_q      <= i_bit && is_op;
        st_data_q    <= use_rd ? rd_val : '0;
        instrout_q   <= bus.instrin;
        out_valid_q  <= 1'b1;
      end else begin
        alusignals_q <= '0;
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.alusignals  = alusignals_q;
  assign bus.op1         = op1_q;
  assign bus.op2         = op2_q;
  assign bus.immx        = immx_q;
  assign bus.isimmediate = isimm_q;
  assign bus.st_data     = st_data_q;
  assign bus.instrout    = instrout_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: issue, hazard stalls, bypass, NOPs, reset.
module tb_operand_issue;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  operand_issue_if bus ();
  operand_issue dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc(input int op, input int i, input int rd,
                                      input int rs1, input int low);
    return {op[3:0], i[0], rd[2:0], rs1[2:0], low[4:0]};
  endfunction

  task automatic wb(input bit en, input int addr, input logic [15:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr[2:0];
    bus.wb_data = data;
  endtask

  logic [15:0] w;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.instrin  = '0;
    wb(1'b0, 0, 16'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_alusignals", 16'(bus.alusignals), 16'h0);
    chk("rst_op1", bus.op1, 16'h0);
    chk("rst_stall", bus.stall_count, 16'h0);
    chk("rst_ready", 16'(bus.in_ready), 16'h1);

    // Load r1=5, r2=3
    wb(1'b1, 1, 16'h0005); tick();
    wb(1'b1, 2, 16'h0003); tick();
    wb(1'b0, 0, 16'h0);

    // add r3,r1,r2
    w = enc(0, 0, 3, 1, 2 << 2);
    bus.instrin = w; bus.in_valid = 1'b1; #1;
    chk("add_ready", 16'(bus.in_ready), 16'h1);
    tick();
    chk("add_alu", 16'(bus.alusignals), 16'h0001);
    chk("add_op1", bus.op1, 16'h0005);
    chk("add_op2", bus.op2, 16'h0003);
    chk("add_isimm", 16'(bus.isimmediate), 16'h0);
    chk("add_valid", 16'(bus.out_valid), 16'h1);
    chk("add_instrout", bus.instrout, w);

    // sub r4,r3,#2 waits on r3
    bus.instrin = enc(3, 1, 4, 3, 2); #1;
    chk("sub_stall_ready", 16'(bus.in_ready), 16'h0);
    tick();
    chk("sub_stall_valid", 16'(bus.out_valid), 16'h0);
    chk("sub_stall_alu", 16'(bus.alusignals), 16'h0);
    chk("sub_stall_hold_op1", bus.op1, 16'h0005);
    chk("stall_1", bus.stall_count, 16'd1);
    tick();
    chk("stall_2", bus.stall_count, 16'd2);
    wb(1'b1, 3, 16'h0008); #1;
    chk("sub_wb_ready", 16'(bus.in_ready), 16'h1);
    tick();
    wb(1'b0, 0, 16'h0);
    chk("sub_alu", 16'(bus.alusignals), 16'h0008);
    chk("sub_op1_bypass", bus.op1, 16'h0008);
    chk("sub_immx", 16'(bus.immx), 16'h0002);
    chk("sub_isimm", 16'(bus.isimmediate), 16'h1);
    chk("sub_op2_zero", bus.op2, 16'h0);
    chk("stall_hold", bus.stall_count, 16'd2);

    // cmp r1,r2 then not r5,r7 (flags hazard)
    bus.instrin = enc(5, 0, 0, 1, 2 << 2); #1;
    chk("cmp_ready", 16'(bus.in_ready), 16'h1);
    tick();
    chk("cmp_alu", 16'(bus.alusignals), 16'h0020);
    chk("cmp_op1", bus.op1, 16'h0005);
    chk("cmp_op2", bus.op2, 16'h0003);
    bus.instrin = enc(9, 0, 5, 7, 0); #1;
    chk("not_stall_ready", 16'(bus.in_ready), 16'h0);
    tick();
    chk("not_stall_valid", 16'(bus.out_valid), 16'h0);
    chk("stall_3", bus.stall_count, 16'd3);
    wb(1'b1, 7, 16'h0002); #1;
    chk("not_wb_ready", 16'(bus.in_ready), 16'h1);
    tick();
    wb(1'b0, 0, 16'h0);
    chk("not_alu", 16'(bus.alusignals), 16'h0200);
    chk("not_op1_flags", bus.op1, 16'h0002);

    // st r2,[r1+4] with r2 written in the same cycle
    bus.in_valid = 1'b0;
    wb(1'b1, 1, 16'h0010); tick();
    wb(1'b1, 2, 16'h00AA);
    bus.instrin = enc(2, 1, 2, 1, 4); bus.in_valid = 1'b1; #1;
    chk("st_ready", 16'(bus.in_ready), 16'h1);
    tick();
    wb(1'b0, 0, 16'h0);
    chk("st_alu", 16'(bus.alusignals), 16'h0004);
    chk("st_op1", bus.op1, 16'h0010);
    chk("st_immx", 16'(bus.immx), 16'h0004);
    chk("st_data", bus.st_data, 16'h00AA);
    // st leaves r2 free, so mov r2,r0 issues right behind it
    bus.instrin = enc(6, 0, 2, 0, 0); #1;
    chk("mov_ready", 16'(bus.in_ready), 16'h1);
    tick();
    chk("mov_alu", 16'(bus.alusignals), 16'h0040);
    chk("mov_op2", bus.op2, 16'h0000);
    chk("mov_st_data_zero", bus.st_data, 16'h0000);

    // NOP naming busy registers still issues
    w = enc(14, 1, 2, 4, 7);
    bus.instrin = w; #1;
    chk("nop_ready", 16'(bus.in_ready), 16'h1);
    tick();
    chk("nop_valid", 16'(bus.out_valid), 16'h1);
    chk("nop_alu", 16'(bus.alusignals), 16'h0);
    chk("nop_isimm", 16'(bus.isimmediate), 16'h0);
    chk("nop_immx", 16'(bus.immx), 16'h0007);
    bus.in_valid = 1'b0;
    tick();
    chk("idle_valid", 16'(bus.out_valid), 16'h0);
    chk("idle_alu", 16'(bus.alusignals), 16'h0);
    chk("idle_instrout_hold", bus.instrout, w);
    chk("idle_no_stall", bus.stall_count, 16'd3);

    // Self-dependent add r1,r1,r1
    bus.instrin = enc(0, 0, 1, 1, 1 << 2); bus.in_valid = 1'b1; #1;
    chk("self_ready", 16'(bus.in_ready), 16'h1);
    tick();
    chk("self_op1", bus.op1, 16'h0010);
    chk("self_op2", bus.op2, 16'h0010);

    // WAW: mov r4 while r4 busy
    bus.instrin = enc(6, 0, 4, 0, 0); #1;
    chk("waw_ready", 16'(bus.in_ready), 16'h0);
    tick();
    chk("stall_4", bus.stall_count, 16'd4);

    // add r3,r0,r0 then sub r4,r3,#2 stalls
    bus.instrin = enc(0, 0, 3, 0, 0); #1;
    chk("add3_ready", 16'(bus.in_ready), 16'h1);
    tick();
    bus.instrin = enc(3, 1, 4, 3, 2); #1;
    chk("sub2_stall_ready", 16'(bus.in_ready), 16'h0);
    tick();
    chk("stall_5", bus.stall_count, 16'd5);

    // Reset while stalled, writeback in the reset cycle is dropped
    rst = 1'b1;
    wb(1'b1, 6, 16'h1234);
    tick();
    rst = 1'b0;
    wb(1'b0, 0, 16'h0);
    #1;
    chk("rst2_stall", bus.stall_count, 16'h0);
    chk("rst2_valid", 16'(bus.out_valid), 16'h0);
    chk("rst2_alu", 16'(bus.alusignals), 16'h0);
    chk("rst2_op1", bus.op1, 16'h0);
    chk("rst2_op2", bus.op2, 16'h0);
    chk("rst2_instrout", bus.instrout, 16'h0);
    chk("rst2_immx", 16'(bus.immx), 16'h0);
    chk("rst2_isimm", 16'(bus.isimmediate), 16'h0);
    chk("rst2_busy_clear", 16'(bus.in_ready), 16'h1);
    tick();
    chk("rst2_sub_alu", 16'(bus.alusignals), 16'h0008);
    chk("rst2_r3_zero", bus.op1, 16'h0);
    chk("rst2_stall_after", bus.stall_count, 16'h0);

    // add r0,r1,r6: both cleared by reset, r6 write ignored
    bus.instrin = enc(0, 0, 0, 1, 6 << 2); #1;
    chk("rd_r1r6_ready", 16'(bus.in_ready), 16'h1);
    tick();
    chk("r1_reset", bus.op1, 16'h0);
    chk("r6_wb_ignored", bus.op2, 16'h0);
    bus.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
